// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-port data memory between the pipelined CPU and a host
//   loader/debug port. The CPU owns the memory by default. A host request
//   takes the memory over for a bounded burst. While the host owns the memory,
//   the CPU is frozen through its enable input. After each burst the CPU is
//   guaranteed a minimum run window before the host can be granted again.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   en_in / cpu_enable          global CPU enable in, gated enable out to CPU
//   cpu_addr/we/wdata/rdata     CPU data-memory side
//   host_req/we/addr/wdata      host access request (one beat per cycle)
//   host_gnt                    host owns the memory; beat accepted on req&gnt
//   host_rvalid/host_rdata      registered read return, one cycle after a read
//   mem_addr/we/wdata/rdata     data-memory side (combinational read)
module dmem_port_arbiter #(
    parameter int AW        = 9,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4,
    parameter int CPU_MIN   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    output logic          cpu_enable,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_we,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int GW = $clog2(CPU_MIN + 1);
    localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST - 1);
    localparam logic [GW-1:0] GUARD_FULL = GW'(CPU_MIN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOST   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [BW-1:0] beat_cnt_r;
    logic [GW-1:0] guard_cnt_r;
    logic          host_rvalid_r;
    logic [DW-1:0] host_rdata_r;
    logic          host_accept_s;

    // A beat is accepted only while the host actually owns the memory.
    assign host_accept_s = host_req & (state_r == ST_HOST);

    // The CPU always sees the memory read port; it is frozen whenever the
    // value belongs to someone else.
    assign cpu_rdata   = mem_rdata;
    assign host_rvalid = host_rvalid_r;
    assign host_rdata  = host_rdata_r;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (host_req && (guard_cnt_r == GUARD_FULL)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                state_s = ST_HOST;
            end
            ST_HOST: begin
                // Leave when the host goes quiet or its final beat is taken.
                if (!host_req) begin
                    state_s = ST_RETURN;
                end else if (beat_cnt_r == BEAT_LAST) begin
                    state_s = ST_RETURN;
                end else begin
                    state_s = ST_HOST;
                end
            end
            ST_RETURN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: memory mux, CPU freeze and host grant.
    always_comb begin
        cpu_enable = 1'b0;
        host_gnt   = 1'b0;
        mem_addr   = cpu_addr;
        mem_we     = 1'b0;
        mem_wdata  = cpu_wdata;
        case (state_r)
            ST_IDLE: begin
                cpu_enable = en_in;
                mem_we     = cpu_we;
            end
            ST_DRAIN: begin
                // Address stays on the CPU so its last write can settle.
                mem_we = 1'b0;
            end
            ST_HOST: begin
                host_gnt  = 1'b1;
                mem_addr  = host_addr;
                mem_we    = host_req & host_we;
                mem_wdata = host_wdata;
            end
            ST_RETURN: begin
                mem_we = 1'b0;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Burst length counter and CPU run-window guard counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_r  <= {BW{1'b0}};
            guard_cnt_r <= GUARD_FULL;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (guard_cnt_r != GUARD_FULL) begin
                        guard_cnt_r <= guard_cnt_r + GW'(1);
                    end
                end
                ST_HOST: begin
                    if (host_accept_s) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                    end
                end
                ST_RETURN: begin
                    beat_cnt_r  <= {BW{1'b0}};
                    guard_cnt_r <= {GW{1'b0}};
                end
                default: begin
                    beat_cnt_r  <= beat_cnt_r;
                    guard_cnt_r <= guard_cnt_r;
                end
            endcase
        end
    end

    // Host read return: one-cycle valid pulse, data held until the next read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= {DW{1'b0}};
        end else if (host_accept_s && !host_we) begin
            host_rvalid_r <= 1'b1;
            host_rdata_r  <= mem_rdata;
        end else begin
            host_rvalid_r <= 1'b0;
        end
    end

endmodule
